adpll_tune_ctrl: RTL and testbench

//  Sequences DCO capacitor-bank tuning for the ADPLL: PVT (c_l) -> ACQ (c_m) -> TRK (c_s).

---
 rtl/adpll_ctrl_pkg.sv | 24 ++
 rtl/adpll_bank_tuner.sv | 65 ++++++
 rtl/adpll_tune_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_adpll_tune_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_ctrl_pkg.sv
// Shared types for the ADPLL tuning controller: FSM state encoding, mode codes
// and the phase-error sign helper.
package adpll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PWRUP = 3'd1,
      ST_PVT   = 3'd2,
      ST_ACQ   = 3'd3,
      ST_TRK   = 3'd4,
      ST_OPEN  = 3'd5
   } tune_state_t;

   localparam logic [1:0] MODE_PD   = 2'd0;
   localparam logic [1:0] MODE_TEST = 2'd1;
   localparam logic [1:0] MODE_RX   = 2'd2;
   localparam logic [1:0] MODE_TX   = 2'd3;

   // 2'b01 positive, 2'b11 negative, 2'b00 zero
   function automatic logic [1:0] phe_sign(input logic msb, input logic nz);
      return !nz ? 2'b00 : (msb ? 2'b11 : 2'b01);
   endfunction

endpackage

// File: rtl/adpll_bank_tuner.sv
// One capacitor bank: saturating up/down code with sign-reversal (flip) counting.
// done pulses on the step that completes SETTLE_FLIPS consecutive flips.
module adpll_bank_tuner #(
   parameter int W            = 8,
   parameter int SETTLE_FLIPS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_mid,
   input  logic         step,
   input  logic         dn,
   output logic [W-1:0] code,
   output logic         done
);

   localparam int FW = $clog2(SETTLE_FLIPS + 1);
   localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0]  code_q, code_d;
   logic          last_vld_q, last_vld_d;
   logic          last_dn_q, last_dn_d;
   logic [FW-1:0] flips_q, flips_d;
   logic          sat, move, flip;

   // A step into a rail is dropped entirely: no code change and no effect on flip history.
   assign sat  = dn ? (code_q == '0) : (code_q == '1);
   assign move = step && !sat && !load_mid;
   assign flip = last_vld_q && (last_dn_q != dn);
   assign done = move && flip && (flips_q == FW'(SETTLE_FLIPS - 1));
   assign code = code_q;

   always_comb begin
      code_d     = code_q;
      last_vld_d = last_vld_q;
      last_dn_d  = last_dn_q;
      flips_d    = flips_q;
      if (load_mid) begin
         code_d     = MID;
         last_vld_d = 1'b0;
         last_dn_d  = 1'b0;
         flips_d    = '0;
      end else if (move) begin
         code_d     = dn ? code_q - W'(1) : code_q + W'(1);
         last_vld_d = 1'b1;
         last_dn_d  = dn;
         if (flip && !done) flips_d = flips_q + FW'(1);
         else               flips_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_q     <= MID;
         last_vld_q <= 1'b0;
         last_dn_q  <= 1'b0;
         flips_q    <= '0;
      end else begin
         code_q     <= code_d;
         last_vld_q <= last_vld_d;
         last_dn_q  <= last_dn_d;
         flips_q    <= flips_d;
      end
   end

endmodule

// File: rtl/adpll_tune_ctrl.sv
// ADPLL DCO tuning sequencer: power-up, then PVT (c_l) -> ACQ (c_m) -> TRK (c_s) with lock detect.
// Define ADPLL_TUNE_TIMEOUT_EN to add the per-bank sample timeout and the sticky tune_tmo flag.
module adpll_tune_ctrl
   import adpll_ctrl_pkg::*;
#(
   parameter int PHE_W        = 12,
   parameter int L_W          = 5,
   parameter int M_W          = 8,
   parameter int S_W          = 8,
   parameter int PWRUP_CYC    = 64,
   parameter int SETTLE_FLIPS = 4,
   parameter int LOCK_TOL     = 8,
   parameter int LOCK_CNT     = 16,
   parameter int TMO_CYC      = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       adpll_mode,
   input  logic [PHE_W-1:0] phe,
   input  logic             phe_valid,
   output logic             dco_pd,
   output logic             tdc_pd,
   output logic [L_W-1:0]   c_l_code,
   output logic [M_W-1:0]   c_m_code,
   output logic [S_W-1:0]   c_s_code,
   output logic [2:0]       tune_state,
   output logic             channel_lock,
   output logic             tune_tmo
);

   localparam int PW = $clog2(PWRUP_CYC);
   localparam int KW = $clog2(LOCK_CNT);

   tune_state_t   state_q, state_d;
   logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [KW-1:0] lk_cnt_q, lk_cnt_d;
   logic          lock_q, lock_d;
   logic [1:0]    mode_q;
   logic          dco_pd_q, dco_pd_d, tdc_pd_q, tdc_pd_d;

   logic [1:0]       sgn;
   logic             dn, step_any, in_lock, abort, load_mid, tuning, tmo_hit;
   logic [PHE_W-1:0] phe_mag;
   logic             l_done, m_done, s_done_unused;

   assign sgn      = phe_sign(phe[PHE_W-1], |phe);
   assign dn       = (sgn == 2'b01);
   assign step_any = phe_valid && (sgn != 2'b00);
   // Two's-complement magnitude; the most negative word reads correctly as unsigned.
   assign phe_mag  = phe[PHE_W-1] ? (~phe + PHE_W'(1)) : phe;
   assign in_lock  = (phe_mag <= PHE_W'(LOCK_TOL));

   assign abort    = !en || (adpll_mode == MODE_PD) ||
                     ((state_q != ST_IDLE) && (adpll_mode != mode_q));
   assign load_mid = abort || (state_q == ST_IDLE) || (state_q == ST_PWRUP);
   assign tuning   = (state_q == ST_PVT) || (state_q == ST_ACQ);

   adpll_bank_tuner #(.W(L_W), .SETTLE_FLIPS(SETTLE_FLIPS)) u_bank_l (
      .clk(clk), .rst(rst), .load_mid(load_mid),
      .step(step_any && (state_q == ST_PVT)), .dn(dn), .code(c_l_code), .done(l_done));

   adpll_bank_tuner #(.W(M_W), .SETTLE_FLIPS(SETTLE_FLIPS)) u_bank_m (
      .clk(clk), .rst(rst), .load_mid(load_mid),
      .step(step_any && (state_q == ST_ACQ)), .dn(dn), .code(c_m_code), .done(m_done));

   // The fine bank dithers forever, so its settle pulse is not used.
   adpll_bank_tuner #(.W(S_W), .SETTLE_FLIPS(SETTLE_FLIPS)) u_bank_s (
      .clk(clk), .rst(rst), .load_mid(load_mid),
      .step(step_any && (state_q == ST_TRK)), .dn(dn), .code(c_s_code), .done(s_done_unused));

   always_comb begin
      state_d   = state_q;
      pwr_cnt_d = pwr_cnt_q;
      if (!en || (adpll_mode == MODE_PD)) begin
         state_d = ST_IDLE;
      end else if (abort) begin
         state_d   = ST_PWRUP;
         pwr_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_PWRUP;
               pwr_cnt_d = '0;
            end
            ST_PWRUP: begin
               if (pwr_cnt_q == PW'(PWRUP_CYC - 1))
                  state_d = (adpll_mode == MODE_TEST) ? ST_OPEN : ST_PVT;
               else
                  pwr_cnt_d = pwr_cnt_q + PW'(1);
            end
            ST_PVT:  if (l_done || tmo_hit) state_d = ST_ACQ;
            ST_ACQ:  if (m_done || tmo_hit) state_d = ST_TRK;
            default: state_d = state_q;
         endcase
      end
   end

   // Lock counter counts consecutive samples disagreeing with the current lock state.
   always_comb begin
      lock_d   = lock_q;
      lk_cnt_d = lk_cnt_q;
      if ((state_q != ST_TRK) || (state_d != ST_TRK)) begin
         lock_d   = 1'b0;
         lk_cnt_d = '0;
      end else if (phe_valid) begin
         if (in_lock != lock_q) begin
            if (lk_cnt_q == KW'(LOCK_CNT - 1)) begin
               lock_d   = !lock_q;
               lk_cnt_d = '0;
            end else begin
               lk_cnt_d = lk_cnt_q + KW'(1);
            end
         end else begin
            lk_cnt_d = '0;
         end
      end
   end

   assign dco_pd_d = (state_d == ST_IDLE);
   assign tdc_pd_d = (state_d == ST_IDLE) || (state_d == ST_OPEN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pwr_cnt_q <= '0;
         lk_cnt_q  <= '0;
         lock_q    <= 1'b0;
         mode_q    <= MODE_PD;
         dco_pd_q  <= 1'b1;
         tdc_pd_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         pwr_cnt_q <= pwr_cnt_d;
         lk_cnt_q  <= lk_cnt_d;
         lock_q    <= lock_d;
         mode_q    <= adpll_mode;
         dco_pd_q  <= dco_pd_d;
         tdc_pd_q  <= tdc_pd_d;
      end
   end

`ifdef ADPLL_TUNE_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tune_tmo_q, tune_tmo_d;

   assign tmo_hit = tuning && phe_valid && (tmo_cnt_q == TW'(TMO_CYC - 1));

   always_comb begin
      tmo_cnt_d  = tmo_cnt_q;
      tune_tmo_d = tune_tmo_q;
      if (!tuning || (state_d != state_q)) tmo_cnt_d = '0;
      else if (phe_valid)                  tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (state_d == ST_IDLE)        tune_tmo_d = 1'b0;
      else if (tmo_hit && !abort)    tune_tmo_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt_q  <= '0;
         tune_tmo_q <= 1'b0;
      end else begin
         tmo_cnt_q  <= tmo_cnt_d;
         tune_tmo_q <= tune_tmo_d;
      end
   end

   assign tune_tmo = tune_tmo_q;
`else
   // TMO_CYC is never negative, so the timeout path is constant-false here.
   assign tmo_hit  = (TMO_CYC < 0) && tuning;
   assign tune_tmo = 1'b0;
`endif

   assign dco_pd       = dco_pd_q;
   assign tdc_pd       = tdc_pd_q;
   assign tune_state   = state_q;
   assign channel_lock = lock_q;

endmodule

// File: tb/tb_adpll_tune_ctrl.sv
// Randomized bench for adpll_tune_ctrl against a sample-level behavioural model.
module tb_adpll_tune_ctrl;

   logic        clk = 1'b0;
   logic        rst, en, pv;
   logic [1:0]  mode;
   logic [11:0] phe;
   logic        dco_pd, tdc_pd, channel_lock, tune_tmo;
   logic [4:0]  c_l_code;
   logic [7:0]  c_m_code, c_s_code;
   logic [2:0]  tune_state;

   adpll_tune_ctrl dut (
      .clk(clk), .rst(rst), .en(en), .adpll_mode(mode), .phe(phe), .phe_valid(pv),
      .dco_pd(dco_pd), .tdc_pd(tdc_pd), .c_l_code(c_l_code), .c_m_code(c_m_code),
      .c_s_code(c_s_code), .tune_state(tune_state), .channel_lock(channel_lock),
      .tune_tmo(tune_tmo));

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: states IDLE=0 PWRUP=1 PVT=2 ACQ=3 TRK=4 OPEN=5; banks 0=L 1=M 2=S
   int m_st, m_cnt, m_lock, m_lkcnt, m_tmo, m_tcnt, m_pmode;
   int m_code[3], m_last[3], m_flips[3];
   int MAXC[3] = '{31, 255, 255};
   int MIDC[3] = '{16, 128, 128};
   int tgt[3];
   int force_phe = 0, lock_phase = 0;

   function automatic void m_mid();
      for (int b = 0; b < 3; b++) begin
         m_code[b] = MIDC[b]; m_last[b] = 0; m_flips[b] = 0;
      end
   endfunction

   function automatic void m_reset();
      m_st = 0; m_cnt = 0; m_lock = 0; m_lkcnt = 0; m_tmo = 0; m_tcnt = 0; m_pmode = 0;
      m_mid();
   endfunction

   // One nonzero phase-error sample on bank b; returns 1 when the bank settles.
   function automatic bit m_sample(input int b, input int s);
      int nc;
      if (s == 0) return 0;
      nc = m_code[b] - s;
      if (nc < 0 || nc > MAXC[b]) return 0;
      m_code[b] = nc;
      if (m_last[b] != 0 && m_last[b] != s) m_flips[b]++;
      else m_flips[b] = 0;
      m_last[b] = s;
      if (m_flips[b] == 4) begin
         m_flips[b] = 0;
         return 1;
      end
      return 0;
   endfunction

   function automatic void m_step();
      int p, s, ap;
      bit d, t;
      p  = $signed(phe);
      s  = (p > 0) ? 1 : (p < 0) ? -1 : 0;
      ap = (p < 0) ? -p : p;
      if (!en || mode == 2'd0) begin
         m_st = 0; m_mid(); m_lock = 0; m_lkcnt = 0; m_tmo = 0; m_tcnt = 0;
      end else if (m_st != 0 && int'(mode) != m_pmode) begin
         m_st = 1; m_cnt = 0; m_mid(); m_lock = 0; m_lkcnt = 0; m_tcnt = 0;
      end else begin
         case (m_st)
            0: begin m_st = 1; m_cnt = 0; end
            1: if (m_cnt == 63) m_st = (mode == 2'd1) ? 5 : 2; else m_cnt++;
            2, 3: if (pv) begin
               d = m_sample(m_st - 2, s);
               t = 0;
`ifdef ADPLL_TUNE_TIMEOUT_EN
               m_tcnt++;
               t = (m_tcnt == 4096);
`endif
               if (d || t) begin
                  m_st++; m_tcnt = 0;
                  if (t) m_tmo = 1;
               end
            end
            4: if (pv) begin
               void'(m_sample(2, s));
               if (int'(ap <= 8) != m_lock) begin
                  m_lkcnt++;
                  if (m_lkcnt == 16) begin m_lock = !m_lock; m_lkcnt = 0; end
               end else m_lkcnt = 0;
            end
            default: ;
         endcase
      end
      m_pmode = mode;
   endfunction

   function automatic int gen_phe();
      int b, mag, p;
      mag = $urandom_range(1, 300);
      if (m_st >= 2 && m_st <= 4) begin
         b = m_st - 2;
         p = (m_code[b] > tgt[b]) ? mag : -mag;
         if (force_phe != 0) p = force_phe;
         if (m_st == 4 && lock_phase == 1) p = int'($urandom_range(0, 16)) - 8;
         if (m_st == 4 && lock_phase == 2) p = $urandom_range(0, 1) ? 100 : -100;
      end else begin
         p = int'($urandom_range(0, 4095)) - 2048;
      end
      return p;
   endfunction

   task automatic cyc();
      int p;
      p   = gen_phe();
      phe = p[11:0];
      pv  = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      m_step();
      #1;
      chk("state",  tune_state,   m_st);
      chk("dco_pd", dco_pd,       m_st == 0);
      chk("tdc_pd", tdc_pd,       m_st == 0 || m_st == 5);
      chk("c_l",    c_l_code,     m_code[0]);
      chk("c_m",    c_m_code,     m_code[1]);
      chk("c_s",    c_s_code,     m_code[2]);
      chk("lock",   channel_lock, m_lock);
      chk("tmo",    tune_tmo,     m_tmo);
   endtask

   task automatic run_until(input int st, input int budget, input string tag);
      int n = 0;
      while (m_st != st && n < budget) begin cyc(); n++; end
      chk(tag, tune_state, st);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, tune_state, 0);
      chk({tag, "_dco"}, dco_pd, 1);
      chk({tag, "_tdc"}, tdc_pd, 1);
      chk({tag, "_cl"}, c_l_code, 16);
      chk({tag, "_cm"}, c_m_code, 128);
      chk({tag, "_cs"}, c_s_code, 128);
      chk({tag, "_lock"}, channel_lock, 0);
      chk({tag, "_tmo"}, tune_tmo, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; en = 1'b0; mode = 2'd0; phe = '0; pv = 1'b0;
      tgt = '{20, 100, 100};
      m_reset();
      #1 rst = 1'b0;
      #2 chk_idle("reset");
      #9 rst = 1'b1;
      repeat (3) cyc();
      chk_idle("en_off");

      // TEST mode: 64 power-up cycles then open loop
      en = 1'b1; mode = 2'd1;
      repeat (65) cyc();
      chk("open_state", tune_state, 5);
      chk("open_dco", dco_pd, 0);
      chk("open_tdc", tdc_pd, 1);
      chk("open_cl", c_l_code, 16);
      repeat (10) cyc();

      // RX: coarse target 20 dithers 20/21 and settles on 21
      tgt = '{20, $urandom_range(40, 200), $urandom_range(40, 200)};
      mode = 2'd2;
      run_until(3, 2000, "reach_acq");
      chk("cl_frozen", c_l_code, 21);
      run_until(4, 3000, "reach_trk");
      lock_phase = 1;
      n = 0;
      while (m_lock == 0 && n < 300) begin cyc(); n++; end
      chk("lock_set", channel_lock, 1);
      lock_phase = 2;
      n = 0;
      while (m_lock == 1 && n < 300) begin cyc(); n++; end
      chk("lock_clr", channel_lock, 0);
      chk("lock_clr_trk", tune_state, 4);

      // async reset mid-TRK, between clock edges
      lock_phase = 1;
      repeat (8) cyc();
      #3 rst = 1'b0;
      #1 chk_idle("async_rst");
      m_reset();
      lock_phase = 0;
      #2 rst = 1'b1;

      // en dropped mid-ACQ
      tgt = '{$urandom_range(5, 26), $urandom_range(40, 200), 128};
      mode = 2'd3;
      run_until(3, 2000, "tx_acq");
      repeat (3) cyc();
      en = 1'b0;
      cyc();
      chk_idle("en_drop");

      // coarse bank pinned at the lower rail
      en = 1'b1; mode = 2'd2; force_phe = 500;
      run_until(2, 200, "sat_pvt");
      repeat (60) cyc();
      chk("sat_cl", c_l_code, 0);
`ifdef ADPLL_TUNE_TIMEOUT_EN
      run_until(3, 7000, "tmo_acq");
      chk("tmo_flag", tune_tmo, 1);
`else
      repeat (100) cyc();
      chk("no_tmo_state", tune_state, 2);
      chk("no_tmo_flag", tune_tmo, 0);
`endif
      force_phe = 0;

      // mode change while tuning restarts power-up
      mode = (mode == 2'd2) ? 2'd3 : 2'd2;
      cyc();
      chk("mode_restart", tune_state, 1);
      chk("mode_restart_cl", c_l_code, 16);

      // random enable/mode churn
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 2) en = $urandom_range(0, 5) != 0;
         if ($urandom_range(0, 199) < 1) mode = 2'($urandom_range(0, 3));
         tgt[0] = (i % 400 == 0) ? int'($urandom_range(0, 31)) : tgt[0];
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
